// File: rtl/rvc_compress_packer.sv
// Streaming RVC compressor: swaps 32-bit instructions for 16-bit forms where legal and
// packs the parcels little-endian into 32-bit words. Optional counters: RVC_COMPRESS_STATS_EN.
module rvc_compress_packer #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        InValid,
    input  logic [31:0] InInstr,
    output logic        InReady,
    input  logic        Flush,
    output logic        OutValid,
    output logic [31:0] OutWord,
    input  logic        OutReady,
    output logic        Idle
`ifdef RVC_COMPRESS_STATS_EN
    ,
    output logic [31:0] CompCount,
    output logic [31:0] PassCount
`endif
);

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t      st;
    logic [15:0] hold;
    logic        ov;
    logic [31:0] ow;

    logic [15:0] c16;
    logic        is16;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] immi, imms;
    logic        imm6ok;

    assign opc    = InInstr[6:0];
    assign f3     = InInstr[14:12];
    assign rd     = InInstr[11:7];
    assign rs1    = InInstr[19:15];
    assign rs2    = InInstr[24:20];
    assign immi   = InInstr[31:20];
    assign imms   = {InInstr[31:25], InInstr[11:7]};
    // imm fits a signed 6-bit field when bits [11:5] are all copies of bit 5
    assign imm6ok = (immi[11:5] == {7{immi[5]}});

    always_comb begin
        c16  = 16'h0000;
        is16 = 1'b0;
        case (opc)
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    if (rd != 5'd0 && rs1 == rd && immi != 12'd0 && imm6ok) begin
                        c16 = {3'b000, immi[5], rd, immi[4:0], 2'b01};
                        is16 = 1'b1;
                    end else if (rd != 5'd0 && rs1 == 5'd0 && imm6ok) begin
                        c16 = {3'b010, immi[5], rd, immi[4:0], 2'b01};
                        is16 = 1'b1;
                    end
                end else if (f3 == 3'b001 && InInstr[31:26] == 6'd0 && rd != 5'd0 &&
                             rs1 == rd && InInstr[25:20] != 6'd0 &&
                             (XLEN == 64 || !InInstr[25])) begin
                    c16 = {3'b000, InInstr[25], rd, InInstr[24:20], 2'b10};
                    is16 = 1'b1;
                end
            end
            7'b0110011: begin
                if (f3 == 3'b000 && InInstr[31:25] == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                    if (rs1 == 5'd0) begin
                        c16 = {4'b1000, rd, rs2, 2'b10};
                        is16 = 1'b1;
                    end else if (rs1 == rd) begin
                        c16 = {4'b1001, rd, rs2, 2'b10};
                        is16 = 1'b1;
                    end
                end
            end
            7'b0000011: begin
                if (f3 == 3'b010) begin
                    if (rs1 == 5'd2 && rd != 5'd0 && immi[11:8] == 4'd0 && immi[1:0] == 2'd0) begin
                        c16 = {3'b010, immi[5], rd, immi[4:2], immi[7:6], 2'b10};
                        is16 = 1'b1;
                    end else if (rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                                 immi[11:7] == 5'd0 && immi[1:0] == 2'd0) begin
                        c16 = {3'b010, immi[5:3], rs1[2:0], immi[2], immi[6], rd[2:0], 2'b00};
                        is16 = 1'b1;
                    end
                end
            end
            7'b0100011: begin
                if (f3 == 3'b010) begin
                    if (rs1 == 5'd2 && imms[11:8] == 4'd0 && imms[1:0] == 2'd0) begin
                        c16 = {3'b110, imms[5:2], imms[7:6], rs2, 2'b10};
                        is16 = 1'b1;
                    end else if (rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                                 imms[11:7] == 5'd0 && imms[1:0] == 2'd0) begin
                        c16 = {3'b110, imms[5:3], rs1[2:0], imms[2], imms[6], rs2[2:0], 2'b00};
                        is16 = 1'b1;
                    end
                end
            end
            7'b1100111: begin
                if (f3 == 3'b000 && rd == 5'd0 && immi == 12'd0 && rs1 != 5'd0) begin
                    c16 = {4'b1000, rs1, 5'd0, 2'b10};
                    is16 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign InReady  = !ov || OutReady;
    assign OutValid = ov;
    assign OutWord  = ow;
    assign Idle     = (st == EMPTY) && !ov;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st   <= EMPTY;
            hold <= 16'h0000;
            ov   <= 1'b0;
            ow   <= 32'h0;
        end else if (InReady) begin
            ov <= 1'b0;
            if (InValid) begin
                if (st == EMPTY) begin
                    if (is16) begin
                        hold <= c16;
                        st   <= HALF;
                    end else begin
                        ow <= InInstr;
                        ov <= 1'b1;
                    end
                end else begin
                    ov <= 1'b1;
                    if (is16) begin
                        ow <= {c16, hold};
                        st <= EMPTY;
                    end else begin
                        ow   <= {InInstr[15:0], hold};
                        hold <= InInstr[31:16];
                    end
                end
            end else if (Flush && st == HALF) begin
                // pad the odd half-parcel with c.nop so the word decodes cleanly
                ow <= {16'h0001, hold};
                ov <= 1'b1;
                st <= EMPTY;
            end
        end
    end

`ifdef RVC_COMPRESS_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            CompCount <= 32'd0;
            PassCount <= 32'd0;
        end else if (InValid && InReady) begin
            if (is16) CompCount <= CompCount + 32'd1;
            else      PassCount <= PassCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed bench for rvc_compress_packer: compression, packing, flush, backpressure, reset.
module tb_rvc_compress_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        InValid = 1'b0;
    logic [31:0] InInstr = 32'h0;
    logic        InReady;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic [31:0] OutWord;
    logic        OutReady = 1'b1;
    logic        Idle;
`ifdef RVC_COMPRESS_STATS_EN
    logic [31:0] CompCount, PassCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rvc_compress_packer #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .InValid(InValid), .InInstr(InInstr),
        .InReady(InReady), .Flush(Flush), .OutValid(OutValid), .OutWord(OutWord),
        .OutReady(OutReady), .Idle(Idle)
`ifdef RVC_COMPRESS_STATS_EN
        , .CompCount(CompCount), .PassCount(PassCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // drive one instruction, wait (bounded) for acceptance; returns #1 after the transfer edge
    task automatic send(input logic [31:0] ins);
        int n = 0;
        InValid = 1'b1;
        InInstr = ins;
        @(negedge clk);
        while (!InReady && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!InReady) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout observed=%h expected=%h", InReady, 1'b1);
        end
        @(posedge clk); #1;
        InValid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_outword",  OutWord, 32'h0);
        chk("rst_inready",  {31'd0, InReady}, 32'd1);
        chk("rst_idle",     {31'd0, Idle}, 32'd1);
        @(negedge clk) reset_n = 1'b1;
        step();

        // c.addi + c.mv into one word
        send(32'h00140413);
        chk("s1_half_nov",  {31'd0, OutValid}, 32'd0);
        chk("s1_half_idle", {31'd0, Idle}, 32'd0);
        send(32'h00B00533);
        chk("s1_ov",   {31'd0, OutValid}, 32'd1);
        chk("s1_word", OutWord, 32'h852E0405);
        step();
        chk("s1_idle", {31'd0, Idle}, 32'd1);

        // uncompressible pass-through in EMPTY
        send(32'h02B50533);
        chk("s2_ov",   {31'd0, OutValid}, 32'd1);
        chk("s2_word", OutWord, 32'h02B50533);
        step();
        chk("s2_idle", {31'd0, Idle}, 32'd1);
`ifdef RVC_COMPRESS_STATS_EN
        chk("stats_comp", CompCount, 32'd2);
        chk("stats_pass", PassCount, 32'd1);
`endif

        // straddling 32-bit instruction, then flush pad
        send(32'h00140413);
        send(32'h02B50533);
        chk("s3_word", OutWord, 32'h05330405);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("s3_flush_ov",   {31'd0, OutValid}, 32'd1);
        chk("s3_flush_word", OutWord, 32'h000102B5);
        step();
        chk("s3_idle", {31'd0, Idle}, 32'd1);

        // input beats flush when both are high; flush in EMPTY does nothing
        send(32'h00140413);
        Flush = 1'b1;
        send(32'h00B00533);
        chk("s3b_word", OutWord, 32'h852E0405);
        step();
        chk("s3b_noflush", {31'd0, OutValid}, 32'd0);
        Flush = 1'b0;

        // immediate/offset boundaries and the remaining encodings
        send(32'h02040413);
        chk("b_addi32", OutWord, 32'h02040413);
        send(32'h0804A403);
        chk("b_lw128", OutWord, 32'h0804A403);
        send(32'hFE040413);
        chk("b_addim32_held", {31'd0, OutValid}, 32'd0);
        send(32'h00008067);
        chk("b_addim32_jr", OutWord, 32'h80821401);
        send(32'h00341413);
        send(32'h0044A403);
        chk("b_slli_lw", OutWord, 32'h40C0040E);
        send(32'h02041413);
        chk("b_slli32", OutWord, 32'h02041413);
        send(32'h00912423);
        send(32'h00C12083);
        chk("b_swsp_lwsp", OutWord, 32'h40B2C426);
        step();

        // backpressure: word held, input stalled, then drained in order
        OutReady = 1'b0;
        send(32'h02B50533);
        chk("bp_first", OutWord, 32'h02B50533);
        InValid = 1'b1;
        InInstr = 32'h02040413;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_inready", {31'd0, InReady}, 32'd0);
            chk("bp_ov",      {31'd0, OutValid}, 32'd1);
            chk("bp_stable",  OutWord, 32'h02B50533);
        end
        OutReady = 1'b1;
        step();
        InValid = 1'b0;
        chk("bp_drain_ov",   {31'd0, OutValid}, 32'd1);
        chk("bp_drain_word", OutWord, 32'h02040413);
        step();
        chk("bp_done", {31'd0, OutValid}, 32'd0);

        // asynchronous reset while HALF with a pending word
        send(32'h00140413);
        OutReady = 1'b0;
        send(32'h02B50533);
        chk("r_pending", OutWord, 32'h05330405);
        reset_n = 1'b0;
        #1;
        chk("r_ov",   {31'd0, OutValid}, 32'd0);
        chk("r_idle", {31'd0, Idle}, 32'd1);
        chk("r_word", OutWord, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        OutReady = 1'b1;
        step();
        send(32'h00B00533);
        chk("r_empty_held", {31'd0, OutValid}, 32'd0);
        send(32'h02B50533);
        chk("r_next_word", OutWord, 32'h0533852E);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
